// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for a 5-stage pipeline with a multi-cycle watchdog.
// Define HAZARD_PERF_EN to build the stall-cycle and flush performance counters.
module hazard_ctrl #(
  parameter int unsigned MC_MAX = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             ex_mc_busy,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_pause,
  output logic             if_id_pause,
  output logic             if_id_bubble,
  output logic             id_ex_pause,
  output logic             id_ex_bubble,
  output logic             ex_mem_pause,
  output logic             ex_mem_bubble,
  output logic             mem_wb_pause,
  output logic             mem_wb_bubble,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MC_WAIT} state_t;

  localparam int unsigned     WD_W    = $clog2(MC_MAX + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_MAX - 1);

  state_t          r_state;
  state_t          w_next;
  logic [WD_W-1:0] r_wd;
  logic            r_timeout;
  logic            r_mc_ignore;
  logic            w_mem_stall;
  logic            w_mc;
  logic            w_load_use;
  logic            w_wd_fire;

  always_comb begin
    w_mem_stall = mem_req & ~mem_ready;
    w_mc        = ex_mc_busy & ~r_mc_ignore;
    w_load_use  = ex_mem_read & (ex_rd != '0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    // Fires on the MC_MAX-th MC_WAIT cycle, i.e. when the count would reach MC_MAX.
    w_wd_fire   = (r_state == MC_WAIT) & ~w_mem_stall & w_mc & (r_wd == WD_LAST);
  end

  always_comb begin
    w_next        = RUN;
    pc_pause      = 1'b0;
    if_id_pause   = 1'b0;
    if_id_bubble  = 1'b0;
    id_ex_pause   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_pause  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_pause  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!reset_n) begin
      pc_pause     = 1'b1;
      if_id_pause  = 1'b1;
      id_ex_pause  = 1'b1;
      ex_mem_pause = 1'b1;
      mem_wb_pause = 1'b1;
    end else if (w_mem_stall) begin
      pc_pause      = 1'b1;
      if_id_pause   = 1'b1;
      id_ex_pause   = 1'b1;
      ex_mem_pause  = 1'b1;
      mem_wb_bubble = 1'b1;
      w_next        = MEM_WAIT;
    end else if (w_mc) begin
      pc_pause      = 1'b1;
      if_id_pause   = 1'b1;
      id_ex_pause   = 1'b1;
      ex_mem_bubble = 1'b1;
      w_next        = w_wd_fire ? RUN : MC_WAIT;
    end else if (ex_redirect) begin
      if_id_bubble = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (w_load_use) begin
      pc_pause     = 1'b1;
      if_id_pause  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RUN;
      r_wd        <= '0;
      r_timeout   <= 1'b0;
      r_mc_ignore <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((w_next == MC_WAIT) && (r_state != MC_WAIT)) begin
        r_wd <= '0;
      end else if (r_state == MC_WAIT) begin
        r_wd <= r_wd + 1'b1;
      end
      // After a timeout the busy level is treated as stuck until it drops.
      if (w_wd_fire) begin
        r_timeout   <= 1'b1;
        r_mc_ignore <= 1'b1;
      end else if (!ex_mc_busy) begin
        r_mc_ignore <= 1'b0;
      end
    end
  end

  assign mc_timeout = r_timeout;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;
  logic             w_flush;

  assign w_flush = ~w_mem_stall & ~w_mc & ex_redirect;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (pc_pause) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_flush)  r_flush_count  <= r_flush_count + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized self-checking bench for hazard_ctrl against a priority-rule reference model.
module tb_hazard_ctrl;
  localparam int unsigned MC_MAX = 4;
  localparam int unsigned CNT_W  = 16;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [8:0] P_RESET = 9'b110101010;
  localparam logic [8:0] P_MEM   = 9'b110101001;
  localparam logic [8:0] P_MC    = 9'b110100100;
  localparam logic [8:0] P_REDIR = 9'b001010000;
  localparam logic [8:0] P_LU    = 9'b110010000;
  localparam logic [8:0] P_NONE  = 9'b000000000;

  logic clock = 1'b0;
  logic reset_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, ex_mc_busy, mem_req, mem_ready;
  logic pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble;
  logic ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble, mc_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  hazard_ctrl #(.MC_MAX(MC_MAX), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .ex_mc_busy(ex_mc_busy), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_pause(pc_pause), .if_id_pause(if_id_pause), .if_id_bubble(if_id_bubble),
    .id_ex_pause(id_ex_pause), .id_ex_bubble(id_ex_bubble),
    .ex_mem_pause(ex_mem_pause), .ex_mem_bubble(ex_mem_bubble),
    .mem_wb_pause(mem_wb_pause), .mem_wb_bubble(mem_wb_bubble),
    .mc_timeout(mc_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: sticky flag, post-timeout busy masking, run length of shown
  // multi-cycle stalls and plain event counters.
  bit               m_timeout;
  bit               m_ignore;
  int unsigned      m_streak;
  logic [CNT_W-1:0] m_stall;
  logic [CNT_W-1:0] m_flush;
  string            phase;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_timeout = 1'b0;
    m_ignore  = 1'b0;
    m_streak  = 0;
    m_stall   = '0;
    m_flush   = '0;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_redirect = 1'b0; ex_mc_busy = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Checks the current cycle, advances the model, and returns at the next negedge.
  task automatic step();
    logic [8:0] exp_v;
    logic [8:0] got_v;
    bit         lu;
    #1;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (!reset_n)                           exp_v = P_RESET;
    else if (mem_req && !mem_ready)         exp_v = P_MEM;
    else if (ex_mc_busy && !m_ignore)       exp_v = P_MC;
    else if (ex_redirect)                   exp_v = P_REDIR;
    else if (lu)                            exp_v = P_LU;
    else                                    exp_v = P_NONE;
    got_v = {pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble,
             ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble};
    check_eq({phase, "/ctrl"}, 64'(got_v), 64'(exp_v));
    check_eq({phase, "/mc_timeout"}, 64'(mc_timeout), 64'(m_timeout));
    check_eq({phase, "/stall_cycles"}, 64'(stall_cycles), PERF ? 64'(m_stall) : 64'd0);
    check_eq({phase, "/flush_count"}, 64'(flush_count), PERF ? 64'(m_flush) : 64'd0);
    if (!reset_n) begin
      model_reset();
    end else begin
      if (exp_v == P_MC) begin
        m_streak++;
        if (m_streak == MC_MAX + 1) begin
          m_timeout = 1'b1;
          m_ignore  = 1'b1;
          m_streak  = 0;
        end
      end else begin
        m_streak = 0;
      end
      if (!ex_mc_busy) m_ignore = 1'b0;
      if (exp_v[8]) m_stall = m_stall + 1'b1;
      if (exp_v == P_REDIR) m_flush = m_flush + 1'b1;
    end
    @(negedge clock);
  endtask

  task automatic random_run(input int unsigned n);
    int unsigned busy_left = 0;
    for (int unsigned i = 0; i < n; i++) begin
      mem_req     = ($urandom % 4) == 0;
      mem_ready   = $urandom % 2;
      ex_redirect = ($urandom % 6) == 0;
      ex_mem_read = ($urandom % 3) == 0;
      ex_rd       = 5'($urandom % 4);
      id_rs1      = 5'($urandom % 4);
      id_rs2      = 5'($urandom % 4);
      id_use_rs1  = $urandom % 2;
      id_use_rs2  = $urandom % 2;
      if (busy_left == 0 && ($urandom % 12) == 0) busy_left = $urandom_range(1, 9);
      ex_mc_busy = busy_left != 0;
      if (busy_left != 0) busy_left--;
      step();
    end
  endtask

  initial begin
    model_reset();
    idle();
    reset_n = 1'b0;
    phase = "reset";
    @(negedge clock);
    step();
    reset_n = 1'b1;
    step();

    phase = "load_use";
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    step();
    ex_mem_read = 1'b0;
    step();
    phase = "load_use_x0";
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
    step();
    idle();

    phase = "mem_stall";
    mem_req = 1'b1;
    repeat (3) step();
    mem_ready = 1'b1;
    step();
    idle();
    step();

    phase = "redirect";
    ex_redirect = 1'b1;
    step();
    ex_redirect = 1'b0;
    step();

    phase = "combo";
    mem_req = 1'b1; ex_mc_busy = 1'b1; ex_redirect = 1'b1;
    repeat (2) step();
    mem_ready = 1'b1;
    step();
    mem_req = 1'b0; mem_ready = 1'b0;
    step();
    ex_mc_busy = 1'b0;
    step();
    idle();
    step();

    phase = "watchdog";
    ex_mc_busy = 1'b1;
    repeat (8) step();
    check_eq("watchdog/flag_set", 64'(mc_timeout), 64'd1);
    check_eq("watchdog/pause_dropped", 64'(pc_pause), 64'd0);
    ex_mc_busy = 1'b0;
    repeat (2) step();
    check_eq("watchdog/flag_sticky", 64'(mc_timeout), 64'd1);

    phase = "random_a";
    random_run(300);

    phase = "reset_mid";
    idle();
    mem_req = 1'b1;
    repeat (2) step();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("reset_mid/ctrl", 64'({pc_pause, if_id_pause, if_id_bubble, id_ex_pause,
             id_ex_bubble, ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble}),
             64'(P_RESET));
    check_eq("reset_mid/mc_timeout", 64'(mc_timeout), 64'd0);
    check_eq("reset_mid/stall_cycles", 64'(stall_cycles), 64'd0);
    check_eq("reset_mid/flush_count", 64'(flush_count), 64'd0);
    model_reset();
    @(negedge clock);
    step();
    reset_n = 1'b1;
    idle();
    phase = "after_reset";
    ex_redirect = 1'b1;
    step();
    idle();
    step();

    phase = "random_b";
    random_run(300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
